// File: rtl/pre_load_unit_pp_if.sv
// Bundles the weight pre-load unit's load stream and drain outputs.
//   master : producer/consumer side (drives w_valid, w_data, pl_start)
//   slave  : the pre-load unit itself
// Load handshake: a beat moves on a rising clk edge where w_valid and
// w_ready are both 1. w_data must be held stable while w_valid is 1.
// w_ready never depends on w_valid. The drain side has no backpressure.
interface pre_load_unit_pp_if #(
  parameter int SIZE   = 8,
  parameter int WW     = 8,
  parameter int RW     = 5,
  parameter int CW     = WW - RW + 1,
  parameter int CPC    = 3,
  parameter int CROW_W = $clog2(SIZE),
  parameter int EW     = 1 + CROW_W + CW
);
  logic                    w_valid;
  logic                    w_ready;
  logic [WW-1:0]           w_data;
  logic                    load_bank;
  logic                    pl_start;
  logic                    pl_tile_ready;
  logic                    pl_row_valid;
  logic [CROW_W-1:0]       pl_row_idx;
  logic [SIZE*RW-1:0]      pl_row_data;
  logic                    pl_cmp_valid;
  logic [SIZE*CPC*EW-1:0]  pl_cmp_data;
  logic                    pl_cmp_ovf;
  logic                    pl_done;

  modport master (
    output w_valid, w_data, pl_start,
    input  w_ready, load_bank, pl_tile_ready, pl_row_valid, pl_row_idx,
    input  pl_row_data, pl_cmp_valid, pl_cmp_data, pl_cmp_ovf, pl_done
  );

  modport slave (
    input  w_valid, w_data, pl_start,
    output w_ready, load_bank, pl_tile_ready, pl_row_valid, pl_row_idx,
    output pl_row_data, pl_cmp_valid, pl_cmp_data, pl_cmp_ovf, pl_done
  );
endinterface

// File: rtl/pre_load_unit_pp.sv
// Double-buffered weight pre-load unit.
// Loads a column-major SIZE x SIZE tile of WW-bit weights into one of two
// banks, splitting each weight into a reduced RW-bit part and, for values
// outside the signed RW range, a CW-bit compensation part recorded in a
// per-column table of CPC entries. A full bank drains one row per cycle
// after pl_start while the other bank keeps loading.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : pre_load_unit_pp_if.slave (load stream + drain outputs)
//   dbg_state  : {bank1 state, bank0 state} for observation
module pre_load_unit_pp #(
  parameter int SIZE   = 8,
  parameter int WW     = 8,
  parameter int RW     = 5,
  parameter int CW     = WW - RW + 1,
  parameter int CPC    = 3,
  parameter int CROW_W = $clog2(SIZE),
  parameter int EW     = 1 + CROW_W + CW
) (
  input  logic               clk,
  input  logic               rst,
  pre_load_unit_pp_if.slave  bus,
  output logic [3:0]         dbg_state
);
  localparam int NBEAT = SIZE * SIZE;
  localparam int IDX_W = 2 * CROW_W;
  localparam int CNT_W = $clog2(CPC + 1);
  localparam int NENT  = SIZE * CPC;
  localparam int ENT_W = $clog2(NENT);

  typedef enum logic [1:0] {
    B_EMPTY    = 2'd0,
    B_LOADING  = 2'd1,
    B_FULL     = 2'd2,
    B_DRAINING = 2'd3
  } bank_st_t;

  bank_st_t          bank_st [2];
  bank_st_t          st_nxt  [2];
  logic              wb, rb, wb_nxt, rb_nxt;
  logic [IDX_W-1:0]  widx;
  logic              w_ready_q;
  logic              drain_q;
  logic [CROW_W-1:0] row_q;
  logic              done_q;

  logic [RW-1:0]     r_mem   [2][NBEAT];
  logic [EW-1:0]     cmp_tab [2][NENT];
  logic [CNT_W-1:0]  cnt     [2][SIZE];
  logic [1:0]        ovf;

  // Load-side decode of the current beat
  logic              accept, last_beat, start_acc, drain_end;
  logic [CROW_W-1:0] w_col, w_row;
  logic [RW-1:0]     w_r;
  logic [WW:0]       w_diff;
  logic [CW-1:0]     w_c;
  logic              w_outlier;
  logic [CNT_W-1:0]  cnt_sel;
  logic [ENT_W-1:0]  ent_idx;

  assign accept    = bus.w_valid & w_ready_q;
  assign last_beat = accept && (widx == IDX_W'(NBEAT - 1));
  assign start_acc = bus.pl_start && (bank_st[rb] == B_FULL) && !drain_q;
  assign drain_end = drain_q && (row_q == CROW_W'(SIZE - 1));

  // Column-major order: the upper index bits pick the column
  assign w_col = widx[IDX_W-1:CROW_W];
  assign w_row = widx[CROW_W-1:0];
  assign w_r   = bus.w_data[RW-1:0];

  // In range iff every bit from the RW sign position upward matches
  assign w_outlier = !((&bus.w_data[WW-1:RW-1]) || !(|bus.w_data[WW-1:RW-1]));

  // W - sext(R) has RW zero LSBs, so dropping them is an exact shift
  assign w_diff = {bus.w_data[WW-1], bus.w_data} - {{(WW - RW + 1){w_r[RW-1]}}, w_r};
  assign w_c    = w_diff[WW:RW];

  assign cnt_sel = cnt[wb][w_col];
  assign ent_idx = ENT_W'(int'(w_col) * CPC + int'(cnt_sel));

  // Bank transitions; load and drain touch different banks, so both
  // events of a cycle always apply.
  always_comb begin
    st_nxt[0] = bank_st[0];
    st_nxt[1] = bank_st[1];
    wb_nxt    = wb;
    rb_nxt    = rb;
    if (accept) begin
      if (last_beat) begin
        st_nxt[wb] = B_FULL;
        wb_nxt     = ~wb;
      end else begin
        st_nxt[wb] = B_LOADING;
      end
    end
    if (start_acc) st_nxt[rb] = B_DRAINING;
    if (drain_end) begin
      st_nxt[rb] = B_EMPTY;
      rb_nxt     = ~rb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_st[0] <= B_EMPTY;
      bank_st[1] <= B_EMPTY;
      wb         <= 1'b0;
      rb         <= 1'b0;
      widx       <= '0;
      w_ready_q  <= 1'b0;
      drain_q    <= 1'b0;
      row_q      <= '0;
      done_q     <= 1'b0;
      ovf        <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int e = 0; e < NENT; e++) cmp_tab[b][e] <= '0;
        for (int c = 0; c < SIZE; c++) cnt[b][c] <= '0;
      end
    end else begin
      bank_st[0] <= st_nxt[0];
      bank_st[1] <= st_nxt[1];
      wb         <= wb_nxt;
      rb         <= rb_nxt;
      // Registered from next state so a bank freed this edge is writable
      // in the very cycle it reads EMPTY.
      w_ready_q  <= (st_nxt[wb_nxt] == B_EMPTY) || (st_nxt[wb_nxt] == B_LOADING);

      if (accept) begin
        widx <= last_beat ? '0 : widx + 1'b1;
        if (w_outlier) begin
          if (cnt_sel < CNT_W'(CPC)) begin
            cmp_tab[wb][ent_idx] <= {1'b1, w_row, w_c};
            cnt[wb][w_col]       <= cnt_sel + 1'b1;
          end else begin
            ovf[wb] <= 1'b1;
          end
        end
      end

      if (start_acc) begin
        drain_q <= 1'b1;
        row_q   <= '0;
        done_q  <= (SIZE == 1);
      end else if (drain_q) begin
        if (drain_end) begin
          drain_q <= 1'b0;
          row_q   <= '0;
          done_q  <= 1'b0;
          // Emptied bank starts its next tile with a clean table
          ovf[rb] <= 1'b0;
          for (int e = 0; e < NENT; e++) cmp_tab[rb][e] <= '0;
          for (int c = 0; c < SIZE; c++) cnt[rb][c] <= '0;
        end else begin
          row_q  <= row_q + 1'b1;
          done_q <= (row_q == CROW_W'(SIZE - 2));
        end
      end
    end
  end

  // Reduced-weight storage needs no reset: a bank is only read after a
  // complete tile has been written into it.
  always_ff @(posedge clk) begin
    if (accept) r_mem[wb][widx] <= w_r;
  end

  logic [SIZE*RW-1:0]     row_data;
  logic [SIZE*CPC*EW-1:0] cmp_data;

  always_comb begin
    row_data = '0;
    cmp_data = '0;
    if (drain_q) begin
      for (int c = 0; c < SIZE; c++) row_data[c*RW +: RW] = r_mem[rb][{CROW_W'(c), row_q}];
      for (int e = 0; e < NENT; e++) cmp_data[e*EW +: EW] = cmp_tab[rb][e];
    end
  end

  assign bus.w_ready       = w_ready_q;
  assign bus.load_bank     = wb;
  assign bus.pl_tile_ready = (bank_st[rb] == B_FULL);
  assign bus.pl_row_valid  = drain_q;
  assign bus.pl_row_idx    = row_q;
  assign bus.pl_row_data   = row_data;
  assign bus.pl_cmp_valid  = drain_q;
  assign bus.pl_cmp_data   = cmp_data;
  assign bus.pl_cmp_ovf    = drain_q & ovf[rb];
  assign bus.pl_done       = done_q;
  assign dbg_state         = {bank_st[1], bank_st[0]};
endmodule

// File: tb/tb_pre_load_unit_pp.sv
// Testbench for pre_load_unit_pp: directed tiles, randomized concurrent
// load/drain, backpressure, coincident load/drain completion and resets.
// Expected drain output is computed from the accepted weight stream with
// integer arithmetic.
module tb_pre_load_unit_pp;
  localparam int SIZE = 8;
  localparam int RW   = 5;
  localparam int CPC  = 3;
  localparam int EW   = 8;
  localparam int NB   = SIZE * SIZE;

  logic       clk;
  logic       rst;
  logic [3:0] dbg_state;

  pre_load_unit_pp_if u_if ();

  pre_load_unit_pp u_dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (u_if),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [7:0]             exp_q [$];
  logic [7:0]             cur_tile [NB];
  logic [7:0]             stim [NB];
  logic [SIZE*CPC*EW-1:0] exp_cmp;
  logic                   exp_ovf;
  int n_checks = 0;
  int n_errors = 0;
  int mon_row = 0;
  int beats_since_rst = 0;
  int tiles_loaded = 0;
  int tiles_drained = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Signed value of the low RW bits of w (the reduced weight)
  function automatic int red_of(input int w);
    int m;
    m = ((w % 32) + 32) % 32;
    if (m >= 16) m = m - 32;
    return m;
  endfunction

  task automatic build_expect();
    int n, sw, rs, cv;
    exp_cmp = '0;
    exp_ovf = 1'b0;
    for (int c = 0; c < SIZE; c++) begin
      n = 0;
      for (int r = 0; r < SIZE; r++) begin
        sw = int'($signed(cur_tile[c*SIZE + r]));
        if (sw < -16 || sw > 15) begin
          if (n < CPC) begin
            rs = red_of(sw);
            cv = (sw - rs) / 32;
            exp_cmp[(c*CPC + n)*EW +: EW] = {1'b1, 3'(r), 4'(cv)};
            n++;
          end else begin
            exp_ovf = 1'b1;
          end
        end
      end
    end
  endtask

  // ---------------- drain monitor ----------------
  always @(negedge clk) begin
    logic [SIZE*RW-1:0] exp_row;
    if (!rst) begin
      if (u_if.pl_row_valid) begin
        if (mon_row == 0) begin
          if (exp_q.size() >= NB) begin
            for (int i = 0; i < NB; i++) cur_tile[i] = exp_q.pop_front();
            build_expect();
          end else begin
            check("tile_avail", exp_q.size(), NB);
          end
        end
        for (int c = 0; c < SIZE; c++)
          exp_row[c*RW +: RW] = 5'(red_of(int'($signed(cur_tile[c*SIZE + mon_row]))));
        check("row_idx", u_if.pl_row_idx, mon_row);
        check("row_data", u_if.pl_row_data, exp_row);
        check("cmp_valid", u_if.pl_cmp_valid, 1'b1);
        check("cmp_data", u_if.pl_cmp_data, exp_cmp);
        check("cmp_ovf", u_if.pl_cmp_ovf, exp_ovf);
        check("done", u_if.pl_done, mon_row == SIZE - 1);
        if (mon_row == SIZE - 1) begin
          mon_row = 0;
          tiles_drained++;
        end else begin
          mon_row++;
        end
      end else begin
        check("idle_outs", {u_if.pl_done, u_if.pl_cmp_valid, u_if.pl_cmp_ovf,
                            |u_if.pl_cmp_data}, 4'd0);
      end
    end
  end

  // ---------------- driver tasks (all entered at a negedge) ----------------
  task automatic do_reset();
    rst = 1'b1;
    u_if.w_valid = 1'b0;
    u_if.pl_start = 1'b0;
    exp_q.delete();
    mon_row = 0;
    beats_since_rst = 0;
    tiles_loaded = 0;
    tiles_drained = 0;
    repeat (2) @(negedge clk);
    check("rst_ctrl", {u_if.w_ready, u_if.load_bank, u_if.pl_tile_ready,
                       u_if.pl_row_valid, u_if.pl_row_idx, u_if.pl_done}, 8'd0);
    check("rst_data", {u_if.pl_row_data, u_if.pl_cmp_valid, u_if.pl_cmp_data,
                       u_if.pl_cmp_ovf}, '0);
    rst = 1'b0;
    check("wready_at_deassert", u_if.w_ready, 1'b0);
    @(negedge clk);
    check("wready_after_rst", u_if.w_ready, 1'b1);
    check("load_bank_after_rst", u_if.load_bank, 1'b0);
  endtask

  task automatic send_beat(input logic [7:0] w);
    int waited = 0;
    u_if.w_valid = 1'b1;
    u_if.w_data  = w;
    while (!u_if.w_ready && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (!u_if.w_ready) begin
      check("beat_timeout", 1'b0, 1'b1);
      u_if.w_valid = 1'b0;
      return;
    end
    exp_q.push_back(w);
    beats_since_rst++;
    if (beats_since_rst % NB == 0) tiles_loaded++;
    @(negedge clk);
    u_if.w_valid = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi, input int gap_max);
    for (int i = lo; i <= hi; i++) begin
      send_beat(stim[i]);
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
    end
  endtask

  task automatic start_drain();
    int n = 0;
    while (!u_if.pl_tile_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("tile_ready_wait", u_if.pl_tile_ready, 1'b1);
    u_if.pl_start = 1'b1;
    @(negedge clk);
    u_if.pl_start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!u_if.pl_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", u_if.pl_done, 1'b1);
    @(negedge clk);
  endtask

  task automatic mk_rand();
    int dense, v;
    dense = $urandom_range(0, 1);
    for (int i = 0; i < NB; i++) begin
      if ($urandom_range(0, 3) < 1 + 2*dense) stim[i] = 8'($urandom_range(0, 255));
      else begin
        v = int'($urandom_range(0, 31)) - 16;
        stim[i] = 8'(v);
      end
    end
  endtask

  task automatic mk_fill(input logic [7:0] w);
    for (int i = 0; i < NB; i++) stim[i] = w;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit seen_done;
    rst = 1'b1;
    u_if.w_valid = 1'b0;
    u_if.w_data = '0;
    u_if.pl_start = 1'b0;
    @(negedge clk);
    do_reset();

    // Directed tiles: all 3; column 2 extremes; column 0 overflow
    mk_fill(8'd3);
    send_range(0, NB - 1, 0);
    start_drain();
    wait_done();

    mk_fill(8'd0);
    stim[2*SIZE + 1] = 8'h7F;
    stim[2*SIZE + 4] = 8'h80;
    send_range(0, NB - 1, 1);
    start_drain();
    wait_done();

    mk_fill(8'd0);
    for (int r = 0; r < SIZE; r++) stim[r] = 8'd20;
    send_range(0, NB - 1, 0);
    start_drain();
    wait_done();

    // Randomized concurrent loading and draining
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          mk_rand();
          send_range(0, NB - 1, 3);
        end
      end
      begin
        for (int k = 0; k < 6; k++) begin
          repeat ($urandom_range(0, 5)) @(negedge clk);
          start_drain();
          if ($urandom_range(0, 1) == 1) begin
            @(negedge clk);
            u_if.pl_start = 1'b1;
            @(negedge clk);
            u_if.pl_start = 1'b0;
          end
          wait_done();
        end
      end
    join

    // Two tiles back-to-back with no drain: both banks fill
    mk_rand();
    send_range(0, NB - 1, 0);
    mk_rand();
    send_range(0, NB - 1, 0);
    check("wready_both_full", u_if.w_ready, 1'b0);
    check("tile_ready_both_full", u_if.pl_tile_ready, 1'b1);
    mk_rand();
    fork
      start_drain();
      begin
        int n = 0;
        while (!u_if.pl_done && n < 100) begin
          @(negedge clk);
          n++;
        end
        check("bp_done_seen", u_if.pl_done, 1'b1);
        check("wready_at_done", u_if.w_ready, 1'b0);
        @(negedge clk);
        check("wready_freed", u_if.w_ready, 1'b1);
      end
      send_beat(stim[0]);
    join
    send_range(1, NB - 1, 0);
    start_drain();
    wait_done();
    start_drain();
    wait_done();
    check("tiles_before_rst", tiles_drained, tiles_loaded);

    // Reset after 37 beats discards the partial tile
    mk_rand();
    send_range(0, 36, 0);
    do_reset();
    mk_rand();
    send_range(0, NB - 1, 1);
    start_drain();
    wait_done();

    // Reset mid-drain aborts without pl_done
    mk_rand();
    send_range(0, NB - 1, 0);
    start_drain();
    repeat (3) @(negedge clk);
    do_reset();
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (u_if.pl_done) seen_done = 1'b1;
      @(negedge clk);
    end
    check("no_done_after_rst", seen_done, 1'b0);
    mk_rand();
    send_range(0, NB - 1, 0);
    start_drain();
    wait_done();

    // Last beat of bank1 lands on the same edge as bank0's drain end
    do_reset();
    mk_rand();
    send_range(0, NB - 1, 0);
    mk_rand();
    send_range(0, 54, 0);
    fork
      begin
        for (int i = 55; i < NB; i++) begin
          if (i == NB - 1) check("coincide_done", u_if.pl_done, 1'b1);
          send_beat(stim[i]);
        end
      end
      begin
        u_if.pl_start = 1'b1;
        @(negedge clk);
        u_if.pl_start = 1'b0;
      end
    join
    check("coincide_tile_ready", u_if.pl_tile_ready, 1'b1);
    check("coincide_load_bank", u_if.load_bank, 1'b0);
    check("coincide_wready", u_if.w_ready, 1'b1);
    check("coincide_beats", beats_since_rst, 2*NB);
    start_drain();
    wait_done();
    check("tiles_accounted", tiles_drained, tiles_loaded);
    check("exp_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pre_load_unit_pp.md
Name: pre_load_unit_pp

Overview:
- Parametrised, double-buffered successor of the weight pre-load path.
- Accepts a column-major stream of WW-bit weights for one SIZE x SIZE tile.
- Splits each weight into a reduced weight (RW bits) and, for outliers only, a compensation weight (CW bits). Records up to CPC compensation entries per column.
- Uses two ping-pong banks so the next tile loads while the current one drains row by row into the systolic/compensation arrays.

Parameters:
SIZE, 8, array dimension (tile is SIZE x SIZE)
WW, 8, input weight width, two's complement
RW, 5, reduced weight width, two's complement
CW, WW-RW+1, compensation weight width, two's complement
CPC, 3, compensation entries per column
CROW_W, $clog2(SIZE), row index width
EW, 1+CROW_W+CW, compensation entry width

Ports:
clk  in  1  clock
rst  in  1  reset
w_valid  in  1  weight beat valid
w_ready  out  1  block can accept a beat
w_data  in  WW  weight, column-major order: beat k -> col k/SIZE, row k%SIZE
load_bank  out  1  bank currently being filled
pl_start  in  1  drain request pulse
pl_tile_ready  out  1  a full bank is waiting to drain
pl_row_valid  out  1  row beat valid
pl_row_idx  out  CROW_W  row being output
pl_row_data  out  SIZE*RW  reduced weights, column c at [c*RW +: RW]
pl_cmp_valid  out  1  compensation table valid
pl_cmp_data  out  SIZE*CPC*EW  entry (c,j) at [(c*CPC+j)*EW +: EW], fields {v,row,C} MSB->LSB
pl_cmp_ovf  out  1  drained tile had a column with >CPC outliers
pl_done  out  1  pulse with last row beat

Behaviour:
Clock and reset:
- One clock `clk`.
- Reset `rst` is asynchronous and active-high. It clears all banks to EMPTY, all counters, and `wb`/`rb` to 0.
- All outputs reset to 0, except `w_ready`, which resets to 0 and rises the first cycle after `rst` deasserts.

Decomposition (per accepted beat W):
- Outlier iff W is outside the signed RW range.
- R = W[RW-1:0] in all cases.
- Outliers only: C = (W - sext(R)) >>> RW, exact and arithmetic. Identity: W = sext(R) + C*2^RW.

Compensation capture:
- Per-column outlier counter.
- If count < CPC: write entry {1, row, C} at index count, then increment.
- If count >= CPC: drop C, keep R, set the bank's sticky ovf bit.
- Unused entries read as all-zero.

Bank state machine:
- States: EMPTY -> LOADING (first beat accepted) -> FULL (beat SIZE*SIZE-1 accepted) -> DRAINING (pl_start accepted) -> EMPTY (cycle after pl_done).
- Bank EMPTY clears its compensation table, counters and ovf.

Load side:
- Write pointer `wb`. `w_ready` = bank[wb] is EMPTY or LOADING.
- Beat accepted when w_valid & w_ready.
- On the last beat, bank -> FULL, wb toggles, index resets to 0.
- With two FULL/DRAINING banks, `w_ready` = 0.

Drain side:
- Read pointer `rb`. `pl_tile_ready` = bank[rb] is FULL.
- pl_start is accepted only when pl_tile_ready = 1 and no drain is active; otherwise it is ignored.
- If accepted at cycle t: rows 0..SIZE-1 are output on cycles t+1..t+SIZE, with pl_row_valid = 1 and pl_row_idx = row.
- pl_cmp_valid, pl_cmp_data and pl_cmp_ovf are held stable for t+1..t+SIZE and are 0 outside that window.
- pl_done = 1 at t+SIZE. Bank -> EMPTY and rb toggles at t+SIZE+1.
- No backpressure on the drain side.

Simultaneous events:
- A last load beat into bank X and pl_done of bank Y in the same cycle both take effect, with no lost beat.
- A freed bank accepts a beat at the earliest on the cycle it becomes EMPTY (w_ready is registered from state).

Reset mid-operation:
- A partial tile is discarded.
- An in-flight drain is aborted and pl_done is not issued.

Test Plan:
- All 64 beats = 8'd3, then pl_start -> 8 row beats, each column 5'd3, idx 0..7; every pl_cmp entry = 0; ovf = 0; pl_done on the 8th beat.
- Column 2: row1 = 8'h7F, row4 = 8'h80, others 0 -> row1 col2 R = 5'h1F, row4 col2 R = 5'h00; entry(2,0) = {1,3'd1,4'h4}; entry(2,1) = {1,3'd4,4'hC}; entry(2,2) = 0.
- Column 0 all 8'd20 (0x14) -> R = 5'h14 for rows 0..7; entries(0,0..2) = {1,row0/1/2,4'h1}; pl_cmp_ovf = 1.
- Stream 128 beats back-to-back, no pl_start -> w_ready drops after beat 128; pl_tile_ready = 1; drain tile0, then w_ready rises the cycle after bank0 frees; drain tile1 shows tile1 data.
- Last beat of bank1 coincident with pl_done of bank0 -> bank1 FULL, bank0 EMPTY next cycle, pl_tile_ready stays 1, all 128 beats accounted.
- rst after 37 beats and mid-drain -> all outputs 0, no pl_done; next 64 beats fill bank0 from index 0 and drain correctly.
